// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between the RV32I
// fetch (IF) and memory (MEM) stages. Data requests always win over fetches.
// Optional build macro ARB_TIMEOUT_EN adds a bus-ack watchdog that forces
// completion after TIMEOUT wait cycles and raises a sticky o_bus_err.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_flush,
  output logic [31:0] o_if_rdata,
  output logic        o_if_valid,
  output logic        o_stall_if,
  input  logic        i_mem_req,
  input  logic        i_mem_we,
  input  logic [3:0]  i_mem_be,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_valid,
  output logic        o_stall_mem,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic        bus_req_d, bus_we_d;
  logic [3:0]  bus_be_d;
  logic [31:0] bus_addr_d, bus_wdata_d;
  logic        if_valid_d, mem_valid_d;
  logic [31:0] if_rdata_d, mem_rdata_d;
  logic        busy, timeout, grant;
  logic        allow_if, allow_mem, mem_ok, if_ok;

  // Stall requests; a port's own valid cycle consumes its request
  assign o_stall_if  = i_if_req & ~o_if_valid;
  assign o_stall_mem = i_mem_req & ~o_mem_valid;
  assign mem_ok      = o_stall_mem;
  assign if_ok       = o_stall_if & ~i_if_flush;
  assign busy        = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout   = busy & ~i_bus_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
  assign o_bus_err = err_q;

  // Wait-cycle counter, restarted on every grant
  always_ff @(posedge i_clk) begin
    if (i_rst || grant) cnt_q <= '0;
    else if (busy && !i_bus_ack) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end
`else
  assign timeout   = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  // Next-state, completion and grant selection
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    bus_req_d   = 1'b0;
    bus_we_d    = o_bus_we;
    bus_be_d    = o_bus_be;
    bus_addr_d  = o_bus_addr;
    bus_wdata_d = o_bus_wdata;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    if_rdata_d  = o_if_rdata;
    mem_rdata_d = o_mem_rdata;
    allow_if    = 1'b0;
    allow_mem   = 1'b0;
    grant       = 1'b0;

    unique case (state_q)
      IDLE: begin
        allow_if  = 1'b1;
        allow_mem = 1'b1;
      end
      FETCH: begin
        if (i_bus_ack) begin
          if_valid_d = ~(drop_q | i_if_flush);
          if_rdata_d = i_bus_rdata;
          drop_d     = 1'b0;
          allow_mem  = 1'b1;
        end else if (timeout) begin
          if_valid_d = ~(drop_q | i_if_flush);
          if_rdata_d = NOP_INSTR;
          drop_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          bus_req_d = 1'b1;
          drop_d    = drop_q | i_if_flush;
        end
      end
      DATA: begin
        if (i_bus_ack) begin
          mem_valid_d = 1'b1;
          mem_rdata_d = o_bus_we ? 32'h0 : i_bus_rdata;
          allow_if    = 1'b1;
        end else if (timeout) begin
          mem_valid_d = 1'b1;
          mem_rdata_d = 32'h0;
          state_d     = IDLE;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Grant: data first (older instruction), completing port excluded
    if (allow_mem && mem_ok) begin
      state_d     = DATA;
      grant       = 1'b1;
      bus_req_d   = 1'b1;
      bus_we_d    = i_mem_we;
      bus_be_d    = i_mem_be;
      bus_addr_d  = i_mem_addr;
      bus_wdata_d = i_mem_wdata;
    end else if (allow_if && if_ok) begin
      state_d     = FETCH;
      grant       = 1'b1;
      bus_req_d   = 1'b1;
      bus_we_d    = 1'b0;
      bus_be_d    = 4'hF;
      bus_addr_d  = i_if_addr;
      bus_wdata_d = 32'h0;
    end else if (allow_mem || allow_if) begin
      state_d = IDLE;
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_be    <= 4'h0;
      o_bus_addr  <= 32'h0;
      o_bus_wdata <= 32'h0;
      o_if_valid  <= 1'b0;
      o_mem_valid <= 1'b0;
      o_if_rdata  <= 32'h0;
      o_mem_rdata <= 32'h0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      o_bus_req   <= bus_req_d;
      o_bus_we    <= bus_we_d;
      o_bus_be    <= bus_be_d;
      o_bus_addr  <= bus_addr_d;
      o_bus_wdata <= bus_wdata_d;
      o_if_valid  <= if_valid_d;
      o_mem_valid <= mem_valid_d;
      o_if_rdata  <= if_rdata_d;
      o_mem_rdata <= mem_rdata_d;
    end
  end

endmodule
